// File: rtl/fan_tach_meter_if.sv
// Fan tach meter bus: groups the tach/fan_on inputs and the measurement outputs.
//   tach        - raw open-collector tach line (asynchronous to sys_clk)
//   fan_on      - fan PWM drive state, high while the fan is driven
//   pulse_count - tach falling edges counted in the last completed window
//   rpm         - pulse_count*60/PPR, saturated to 16 bits
//   valid       - one-cycle strobe when pulse_count/rpm update
//   stall       - high while the fan is driven but not turning
// master: the environment driving tach/fan_on; slave: the meter.
interface fan_tach_meter_if;
    logic        tach;
    logic        fan_on;
    logic [15:0] pulse_count;
    logic [15:0] rpm;
    logic        valid;
    logic        stall;

    modport master (
        output tach, fan_on,
        input  pulse_count, rpm, valid, stall
    );

    modport slave (
        input  tach, fan_on,
        output pulse_count, rpm, valid, stall
    );
endinterface

// File: rtl/fan_tach_meter.sv
// Fan tachometer: counts tach falling edges over a fixed gate window, converts
// to RPM and flags a stalled fan.
// Ports:
//   sys_clk   - single clock, rising edge
//   sys_rst_n - asynchronous active-low reset
//   bus       - fan_tach_meter_if.slave (tach, fan_on in; pulse_count, rpm,
//               valid, stall out)
// Build option: define TACH_DEBOUNCE_EN to add a DEB_CYCLES-long stability
// filter on the synchronized tach line.
module fan_tach_meter #(
    parameter int unsigned GATE_CYCLES   = 50000000,
    parameter int unsigned PPR           = 2,
    parameter int unsigned STALL_WINDOWS = 2,
    parameter int unsigned DEB_CYCLES    = 16
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    fan_tach_meter_if.slave   bus
);

    localparam int unsigned WinW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WinW-1:0] WinLast = WinW'(GATE_CYCLES - 1);
    localparam int unsigned Shift = (PPR == 4) ? 2 : (PPR == 2) ? 1 : 0;
    localparam logic [15:0] StallWin = 16'(STALL_WINDOWS);

    if (!(PPR == 1 || PPR == 2 || PPR == 4)) begin : g_bad_ppr
        $error("fan_tach_meter: PPR must be 1, 2 or 4");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("fan_tach_meter: DEB_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StRun, StSuspect, StStalled} state_e;

    // Synchronizer resets high (tach idles high) so release makes no false edge.
    logic sync1_q, sync2_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.tach;
            sync2_q <= sync1_q;
        end
    end

    logic tach_cond;

`ifdef TACH_DEBOUNCE_EN
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    logic            deb_q;
    logic [DebW-1:0] deb_cnt_q;

    // Follow the synchronized level only after it has differed for DEB_CYCLES cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
        end else if (sync2_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_q <= '0;
        end
    end

    assign tach_cond = deb_q;
`else
    assign tach_cond = sync2_q;
`endif

    logic cond_prev_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cond_prev_q <= 1'b1;
        else            cond_prev_q <= tach_cond;
    end

    logic tach_fall;
    assign tach_fall = cond_prev_q & ~tach_cond;

    logic [WinW-1:0] win_cnt_q;
    logic            win_close;
    assign win_close = (win_cnt_q == WinLast);

    logic [15:0] acc_q;
    logic [15:0] acc_inc;
    // Includes the edge of the current cycle so a close-coincident edge lands in
    // the closing window exactly once.
    assign acc_inc = (tach_fall && acc_q != 16'hFFFF) ? acc_q + 16'd1 : acc_q;

    logic [21:0] rpm_wide;
    logic [15:0] rpm_sat;
    assign rpm_wide = ({6'd0, acc_inc} * 22'd60) >> Shift;
    assign rpm_sat  = (|rpm_wide[21:16]) ? 16'hFFFF : rpm_wide[15:0];

    logic [15:0] pulse_count_q, rpm_q;
    logic        valid_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_cnt_q     <= '0;
            acc_q         <= '0;
            pulse_count_q <= '0;
            rpm_q         <= '0;
            valid_q       <= 1'b0;
        end else begin
            valid_q <= win_close;
            if (win_close) begin
                win_cnt_q     <= '0;
                acc_q         <= '0;
                pulse_count_q <= acc_inc;
                rpm_q         <= rpm_sat;
            end else begin
                win_cnt_q <= win_cnt_q + 1'b1;
                acc_q     <= acc_inc;
            end
        end
    end

    state_e      state_q;
    logic [15:0] miss_q;
    logic        win_zero;
    assign win_zero = (acc_inc == 16'd0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StRun;
            miss_q  <= '0;
        end else if (!bus.fan_on) begin
            state_q <= StRun;
            miss_q  <= '0;
        end else if (win_close) begin
            case (state_q)
                StRun: begin
                    if (win_zero) begin
                        miss_q  <= 16'd1;
                        state_q <= (StallWin <= 16'd1) ? StStalled : StSuspect;
                    end
                end
                StSuspect: begin
                    if (win_zero) begin
                        miss_q <= miss_q + 16'd1;
                        if (miss_q + 16'd1 >= StallWin) state_q <= StStalled;
                    end else begin
                        miss_q  <= '0;
                        state_q <= StRun;
                    end
                end
                StStalled: begin
                    if (!win_zero) begin
                        miss_q  <= '0;
                        state_q <= StRun;
                    end
                end
                default: begin
                    miss_q  <= '0;
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign bus.pulse_count = pulse_count_q;
    assign bus.rpm         = rpm_q;
    assign bus.valid       = valid_q;
    assign bus.stall       = (state_q == StStalled);

endmodule

// File: doc/fan_tach_meter.md
FAN_TACH_METER -- requirements
Module: fan_tach_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000000, giving the measurement window length in sys_clk cycles (1 s at 50 MHz).
REQ-002 The block SHALL have parameter PPR, default 2, giving tach pulses per fan revolution; the only legal values SHALL be 1, 2 and 4.
REQ-003 The block SHALL have parameter STALL_WINDOWS, default 2, giving the number of consecutive zero-pulse windows that declare a stall.
REQ-004 The block SHALL have parameter DEB_CYCLES, default 16, giving the tach debounce stability length in cycles.
REQ-005 sys_clk SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-006 sys_rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-007 tach SHALL be an input, 1 bit wide: the raw open-collector fan tach line, asynchronous to sys_clk.
REQ-008 fan_on SHALL be an input, 1 bit wide: the PWM drive output from the fan PWM stage; high means the fan is driven.
REQ-009 pulse_count SHALL be an output, 16 bits wide: the tach falling edges counted in the last completed window.
REQ-010 rpm SHALL be an output, 16 bits wide: (pulse_count*60/PPR) computed over the last completed window, saturating.
REQ-011 valid SHALL be an output, 1 bit wide: a one-cycle strobe issued when pulse_count and rpm update.
REQ-012 stall SHALL be an output, 1 bit wide: a level that is high while the fan is driven but not turning.

Function
REQ-013 tach SHALL pass through a 2-flop synchronizer before any use.
REQ-014 An edge SHALL be counted on each 1->0 transition of the conditioned tach signal, at most one per cycle.
REQ-015 A window counter SHALL count 0..GATE_CYCLES-1 and wrap; the window closes on the cycle where the count equals GATE_CYCLES-1.
REQ-016 On window close: pulse_count SHALL load the accumulator, including any edge detected in that same cycle; the accumulator SHALL clear to 0; valid SHALL pulse high the following cycle together with the new rpm.
REQ-017 The accumulator SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-018 rpm SHALL be computed as pulse_count*60 shifted right by log2(PPR), using a 22-bit intermediate, and SHALL saturate to 0xFFFF if the result exceeds 16 bits.
REQ-019 Latency SHALL be 1 cycle from window close to valid, and rpm SHALL be stable whenever valid is high.
REQ-020 The stall FSM SHALL have three states: RUN, SUSPECT and STALLED.
REQ-021 In RUN, a window closing with 0 pulses while fan_on is high SHALL move the FSM to SUSPECT and set the miss count to 1.
REQ-022 In SUSPECT, each further zero-pulse window SHALL increment the miss count; when the count reaches STALL_WINDOWS the FSM SHALL go to STALLED; a nonzero window SHALL return it to RUN.
REQ-023 In STALLED, a nonzero window SHALL return the FSM to RUN.
REQ-024 From any state, fan_on low SHALL force the FSM to RUN at that same cycle.
REQ-025 stall SHALL equal (state==STALLED).
REQ-026 If fan_on changes mid-window, the window SHALL NOT restart; only fan_on at window close SHALL be evaluated for stall.
REQ-027 A tach edge coincident with window close SHALL be counted in the closing window, never lost and never double-counted.

Reset
REQ-028 While sys_rst_n is low, pulse_count, rpm, the accumulator, the window counter and the miss count SHALL be 0, valid and stall SHALL be 0, and the FSM SHALL be in RUN.
REQ-029 The synchronizer and debounce flops SHALL reset to 1 (tach idle-high), so that no false edge occurs on reset release.
REQ-030 After reset deassertion, the first window SHALL start at count 0 on the first sys_clk edge.
REQ-031 Reset asserted mid-window SHALL discard the partial window, and no valid SHALL be issued for it.

Configuration
REQ-032 With TACH_DEBOUNCE_EN defined, the conditioned tach SHALL change only after the synchronized tach holds a new level for DEB_CYCLES consecutive cycles, adding DEB_CYCLES cycles of edge latency.
REQ-033 Without TACH_DEBOUNCE_EN, the conditioned tach SHALL equal the synchronizer output and DEB_CYCLES SHALL be unused.

Verification (GATE_CYCLES=1000 for sim)
REQ-034 With fan_on=1 and 10 clean tach periods per window, PPR=2 -> pulse_count=10, rpm=300, and valid high for exactly 1 cycle per 1000 cycles.
REQ-035 With fan_on=1 and tach held high for 3 windows, STALL_WINDOWS=2 -> stall rises 1 cycle after the 2nd window close; one pulse in the next window -> stall clears at that window close.
REQ-036 With fan_on=0 and tach idle -> stall stays 0 and pulse_count=0 every window.
REQ-037 With TACH_DEBOUNCE_EN defined and 3-cycle glitches on tach (DEB_CYCLES=16) -> pulse_count=0; without the macro -> glitches are counted.
REQ-038 With a tach falling edge aligned to the window-close cycle -> that edge appears in the closing window's pulse_count and the next window starts at 0.
REQ-039 With sys_rst_n pulsed low at cycle 500 of a window -> all outputs read 0 asynchronously, and the first valid arrives 1000 cycles after release.
